// File: rtl/bus_initiator.sv
// KS-10 backplane bus initiator: latches a microcode memory request, runs the
// REQ/ACK handshake with a non-existent-memory timeout and holds read data for the CPU.
module bus_initiator #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuREQ,
  input  logic        cpuREAD,
  input  logic        cpuWRITE,
  input  logic [0:13] vmaFLAGS,
  input  logic [14:35] vmaADDR,
  input  logic [0:35] cpuDATAO,
  input  logic        clrNXM,
  output logic        busREQO,
  output logic [0:35] busADDRO,
  output logic [0:35] busDATAO,
  input  logic        busACKI,
  input  logic [0:35] busDATAI,
  output logic [0:35] cpuDATAI,
  output logic        cpuBUSY,
  output logic        cpuDONE,
  output logic        nxmERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_NXM
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [0:35] addr_q, addr_d;
  logic [0:35] dout_q, dout_d;
  logic [0:35] din_q, din_d;
  logic        nxm_q, nxm_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    din_d   = din_q;
    nxm_d   = nxm_q;

    case (state_q)
      S_IDLE: begin
        if (cpuREQ && (cpuREAD || cpuWRITE)) begin
          addr_d  = {vmaFLAGS, vmaADDR};
          if (cpuWRITE) dout_d = cpuDATAO;
          rd_d    = cpuREAD;
          wr_d    = cpuWRITE;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Acknowledge is tested first so it wins over a same-cycle timeout.
        if (busACKI) begin
          if (rd_q) din_d = busDATAI;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_NXM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_NXM: begin
        if (rd_q) din_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Setting from NXM has priority over the CPU clear.
    if (state_q == S_NXM) begin
      nxm_d = 1'b1;
    end else if (clrNXM) begin
      nxm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      din_q   <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
      nxm_q   <= nxm_d;
    end
  end

  assign busREQO  = (state_q == S_REQ);
  assign cpuBUSY  = (state_q != S_IDLE);
  assign cpuDONE  = (state_q == S_DONE) || (state_q == S_NXM);
  assign busADDRO = addr_q;
  assign busDATAO = dout_q;
  assign cpuDATAI = din_q;
  assign nxmERR   = nxm_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: expected completions are queued by the stimulus
// and checked by an independent monitor one cycle after each cpuDONE pulse.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuREQ, cpuREAD, cpuWRITE, clrNXM, busACKI;
  logic [0:13] vmaFLAGS;
  logic [14:35] vmaADDR;
  logic [0:35] cpuDATAO, busDATAI;
  logic        busREQO, cpuBUSY, cpuDONE, nxmERR;
  logic [0:35] busADDRO, busDATAO, cpuDATAI;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [35:0] datai;
    logic        nxm;
  } exp_t;
  exp_t sb[$];

  bus_initiator #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cpuREQ(cpuREQ), .cpuREAD(cpuREAD), .cpuWRITE(cpuWRITE),
    .vmaFLAGS(vmaFLAGS), .vmaADDR(vmaADDR), .cpuDATAO(cpuDATAO),
    .clrNXM(clrNXM),
    .busREQO(busREQO), .busADDRO(busADDRO), .busDATAO(busDATAO),
    .busACKI(busACKI), .busDATAI(busDATAI),
    .cpuDATAI(cpuDATAI), .cpuBUSY(cpuBUSY), .cpuDONE(cpuDONE), .nxmERR(nxmERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0o expected=%0o", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result registers settle one cycle after cpuDONE (NXM updates at the end of its cycle).
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_prev === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 36'd1, 36'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_cpuDATAI", cpuDATAI, e.datai);
        chk("sb_nxmERR", {35'd0, nxmERR}, {35'd0, e.nxm});
      end
    end
    done_prev = cpuDONE;
  end

  // Called in the first REQ cycle; ack_at is the 1-based REQ cycle carrying busACKI (0 = never).
  // Returns in the cpuDONE cycle with the number of busREQO cycles observed.
  task automatic run_cycle(input int ack_at, input logic [35:0] rdata,
                           input logic [35:0] exp_addr, input logic [35:0] exp_dout,
                           output int nreq, output int unstable);
    bit done;
    nreq = 0;
    unstable = 0;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (busREQO) begin
        nreq++;
        if (busADDRO !== exp_addr || busDATAO !== exp_dout) unstable++;
        if (nreq == ack_at) begin
          busACKI  = 1'b1;
          busDATAI = rdata;
        end
      end
      tick();
      busACKI = 1'b0;
      if (cpuDONE) done = 1;
    end
    if (!done) chk("cycle_timeout", 36'd1, 36'd0);
  endtask

  task automatic request(input logic rd, input logic wr, input logic [0:13] fl,
                         input logic [14:35] ad, input logic [35:0] wd);
    cpuREQ   = 1'b1;
    cpuREAD  = rd;
    cpuWRITE = wr;
    vmaFLAGS = fl;
    vmaADDR  = ad;
    cpuDATAO = wd;
    tick();
    cpuREQ   = 1'b0;
    cpuREAD  = 1'b0;
    cpuWRITE = 1'b0;
  endtask

  initial begin
    int nreq, unst;
    exp_t e;
    rst = 1'b1; cpuREQ = 0; cpuREAD = 0; cpuWRITE = 0; clrNXM = 0; busACKI = 0;
    vmaFLAGS = '0; vmaADDR = '0; cpuDATAO = '0; busDATAI = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busREQO", {35'd0, busREQO}, 36'd0);
    chk("rst_busADDRO", busADDRO, 36'd0);
    chk("rst_busDATAO", busDATAO, 36'd0);
    chk("rst_cpuDATAI", cpuDATAI, 36'd0);
    chk("rst_cpuBUSY", {35'd0, cpuBUSY}, 36'd0);
    chk("rst_cpuDONE", {35'd0, cpuDONE}, 36'd0);
    chk("rst_nxmERR", {35'd0, nxmERR}, 36'd0);

    // Read, ACK in the 4th REQ cycle.
    e.datai = 36'o123456654321; e.nxm = 1'b0; sb.push_back(e);
    request(1, 0, 14'd0, 22'o000100, 36'd0);
    chk("rd_busREQO_c1", {35'd0, busREQO}, 36'd1);
    run_cycle(4, 36'o123456654321, 36'o000000000100, 36'd0, nreq, unst);
    chk("rd_req_cycles", 36'(nreq), 36'd4);
    chk("rd_stable", 36'(unst), 36'd0);
    chk("rd_done_busREQO", {35'd0, busREQO}, 36'd0);
    chk("rd_data_in_done", cpuDATAI, 36'o123456654321);
    tick();
    chk("rd_idle_busy", {35'd0, cpuBUSY}, 36'd0);
    chk("rd_idle_done", {35'd0, cpuDONE}, 36'd0);

    // Write, ACK in first REQ cycle; cpuDATAI keeps the previous read.
    e.datai = 36'o123456654321; e.nxm = 1'b0; sb.push_back(e);
    request(0, 1, 14'h2A5A, 22'o1234567, 36'o777000000777);
    run_cycle(1, 36'o555555555555, {14'h2A5A, 22'o1234567}, 36'o777000000777, nreq, unst);
    chk("wr_req_cycles", 36'(nreq), 36'd1);
    chk("wr_stable", 36'(unst), 36'd0);
    chk("wr_busDATAO", busDATAO, 36'o777000000777);
    tick();

    // NXM read: no ACK ever.
    e.datai = 36'd0; e.nxm = 1'b1; sb.push_back(e);
    request(1, 0, 14'd0, 22'o000200, 36'd0);
    run_cycle(0, 36'd0, 36'o000000000200, 36'o777000000777, nreq, unst);
    chk("nxm_req_cycles", 36'(nreq), 36'd64);
    chk("nxm_stable", 36'(unst), 36'd0);
    tick();
    chk("nxm_set", {35'd0, nxmERR}, 36'd1);
    chk("nxm_data_zero", cpuDATAI, 36'd0);
    tick(); tick();
    chk("nxm_sticky", {35'd0, nxmERR}, 36'd1);
    clrNXM = 1'b1;
    tick();
    clrNXM = 1'b0;
    chk("nxm_cleared", {35'd0, nxmERR}, 36'd0);

    // ACK on the final timeout cycle wins.
    e.datai = 36'o765432101234; e.nxm = 1'b0; sb.push_back(e);
    request(1, 0, 14'd0, 22'o000300, 36'd0);
    run_cycle(64, 36'o765432101234, 36'o000000000300, 36'o777000000777, nreq, unst);
    chk("late_ack_req_cycles", 36'(nreq), 36'd64);
    tick();
    chk("late_ack_nxm", {35'd0, nxmERR}, 36'd0);
    chk("late_ack_data", cpuDATAI, 36'o765432101234);

    // Stray ACK in IDLE, then cpuREQ held through REQ and DONE.
    busACKI = 1'b1; busDATAI = 36'o111111111111;
    tick();
    busACKI = 1'b0;
    chk("stray_ack_busy", {35'd0, cpuBUSY}, 36'd0);
    chk("stray_ack_data", cpuDATAI, 36'o765432101234);
    e.datai = 36'o000011112222; e.nxm = 1'b0; sb.push_back(e);
    cpuREQ = 1'b1; cpuREAD = 1'b1; vmaFLAGS = 14'd0; vmaADDR = 22'o000400;
    tick();
    run_cycle(2, 36'o000011112222, 36'o000000000400, 36'o777000000777, nreq, unst);
    chk("held_req_cycles", 36'(nreq), 36'd2);
    tick();
    chk("held_idle_busREQO", {35'd0, busREQO}, 36'd0);
    chk("held_idle_busy", {35'd0, cpuBUSY}, 36'd0);
    e.datai = 36'o333344445555; e.nxm = 1'b0; sb.push_back(e);
    tick();
    cpuREQ = 1'b0; cpuREAD = 1'b0;
    chk("second_cycle_busREQO", {35'd0, busREQO}, 36'd1);
    run_cycle(1, 36'o333344445555, 36'o000000000400, 36'o777000000777, nreq, unst);
    chk("second_req_cycles", 36'(nreq), 36'd1);
    tick();

    // Read-pause-write: both drives data out and captures data in.
    e.datai = 36'o222333444555; e.nxm = 1'b0; sb.push_back(e);
    request(1, 1, 14'h0001, 22'o000500, 36'o111222333444);
    run_cycle(1, 36'o222333444555, {14'h0001, 22'o000500}, 36'o111222333444, nreq, unst);
    chk("rpw_stable", 36'(unst), 36'd0);
    chk("rpw_busDATAO", busDATAO, 36'o111222333444);
    tick();

    // Reset in the middle of REQ: no completion.
    request(1, 0, 14'd0, 22'o000600, 36'd0);
    tick();
    chk("rst_mid_busREQO_before", {35'd0, busREQO}, 36'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busREQO", {35'd0, busREQO}, 36'd0);
    chk("rst_mid_cpuDONE", {35'd0, cpuDONE}, 36'd0);
    chk("rst_mid_busADDRO", busADDRO, 36'd0);
    chk("rst_mid_busDATAO", busDATAO, 36'd0);
    chk("rst_mid_cpuDATAI", cpuDATAI, 36'd0);
    chk("rst_mid_cpuBUSY", {35'd0, cpuBUSY}, 36'd0);
    tick();
    chk("rst_mid_no_done", {35'd0, cpuDONE}, 36'd0);

    // cpuREQ without op bits is ignored.
    cpuREQ = 1'b1; vmaADDR = 22'o000700;
    tick();
    tick();
    cpuREQ = 1'b0;
    chk("noop_busy", {35'd0, cpuBUSY}, 36'd0);
    chk("noop_busREQO", {35'd0, busREQO}, 36'd0);
    chk("noop_addr", busADDRO, 36'd0);
    tick(); tick();
    chk("sb_drained", 36'(sb.size()), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
